// File: rtl/ball_motion_if.sv
// Ball motion control/status bundle.
//   frame_tick  : one-cycle pulse at start of vertical blanking
//   pause       : 1 = ignore frame ticks
//   speed       : step per frame = speed+1 pixels
//   ball_x/y    : ball top-left corner
//   dir_x/y     : 1 = moving right/down, 0 = moving left/up
//   bounce      : pulse with update_done when an axis reversed this frame
//   update_done : pulse when a frame update completes
// master drives the controls (frame timing side); slave is the motion engine.
interface ball_motion_if #(
   parameter int XW = 10,
   parameter int YW = 10
);
   logic          frame_tick;
   logic          pause;
   logic [1:0]    speed;
   logic [XW-1:0] ball_x;
   logic [YW-1:0] ball_y;
   logic          dir_x;
   logic          dir_y;
   logic          bounce;
   logic          update_done;

   modport master (
      output frame_tick, pause, speed,
      input  ball_x, ball_y, dir_x, dir_y, bounce, update_done
   );

   modport slave (
      input  frame_tick, pause, speed,
      output ball_x, ball_y, dir_x, dir_y, bounce, update_done
   );
endinterface

// File: rtl/ball_motion.sv
// Per-frame ball position engine feeding the pixel renderer.
// Each accepted frame tick advances the ball's top-left corner by speed+1
// pixels per axis; an axis that reaches a screen edge is clamped there and
// its direction reverses. X is updated one cycle after the tick, Y the cycle
// after that, then update_done (and bounce, if any axis reversed) pulses.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : ball_motion_if slave (controls in, position/status out)
module ball_motion #(
   parameter int H_RES     = 640,
   parameter int V_RES     = 480,
   parameter int BALL_SIZE = 16,
   parameter int XW        = 10,
   parameter int YW        = 10,
   parameter int INIT_X    = 100,
   parameter int INIT_Y    = 50
) (
   input logic           clk,
   input logic           rst_n,
   ball_motion_if.slave  bus
);

   localparam int            X_MAX_I  = H_RES - BALL_SIZE;
   localparam int            Y_MAX_I  = V_RES - BALL_SIZE;
   localparam logic [XW:0]   X_MAX    = X_MAX_I[XW:0];
   localparam logic [YW:0]   Y_MAX    = Y_MAX_I[YW:0];
   localparam logic [XW-1:0] X_RESET  = INIT_X[XW-1:0];
   localparam logic [YW-1:0] Y_RESET  = INIT_Y[YW-1:0];

   typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y, DONE} state_t;

   state_t        state_q,  state_d;
   logic [2:0]    step_q,   step_d;
   logic [XW-1:0] ball_x_q, ball_x_d;
   logic [YW-1:0] ball_y_q, ball_y_d;
   logic          dir_x_q,  dir_x_d;
   logic          dir_y_q,  dir_y_d;
   logic          flip_q,   flip_d;   // X reversed during the current update
   logic          bounce_q, bounce_d;
   logic          done_q,   done_d;

   // X axis candidate, one bit wider so the sum cannot wrap
   logic [XW:0]   x_ext, x_step, x_sum;
   logic [XW-1:0] x_next;
   logic          x_flip;

   always_comb begin
      x_ext  = {1'b0, ball_x_q};
      x_step = {{(XW-2){1'b0}}, step_q};
      x_sum  = x_ext + x_step;
      x_next = ball_x_q;
      x_flip = 1'b0;
      if (dir_x_q) begin
         if (x_sum >= X_MAX) begin
            x_next = X_MAX[XW-1:0];
            x_flip = 1'b1;
         end else begin
            x_next = x_sum[XW-1:0];
         end
      end else begin
         if (x_ext <= x_step) begin
            x_next = '0;
            x_flip = 1'b1;
         end else begin
            x_next = ball_x_q - x_step[XW-1:0];
         end
      end
   end

   // Y axis candidate, same rule against the vertical limit
   logic [YW:0]   y_ext, y_step, y_sum;
   logic [YW-1:0] y_next;
   logic          y_flip;

   always_comb begin
      y_ext  = {1'b0, ball_y_q};
      y_step = {{(YW-2){1'b0}}, step_q};
      y_sum  = y_ext + y_step;
      y_next = ball_y_q;
      y_flip = 1'b0;
      if (dir_y_q) begin
         if (y_sum >= Y_MAX) begin
            y_next = Y_MAX[YW-1:0];
            y_flip = 1'b1;
         end else begin
            y_next = y_sum[YW-1:0];
         end
      end else begin
         if (y_ext <= y_step) begin
            y_next = '0;
            y_flip = 1'b1;
         end else begin
            y_next = ball_y_q - y_step[YW-1:0];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      ball_x_d = ball_x_q;
      ball_y_d = ball_y_q;
      dir_x_d  = dir_x_q;
      dir_y_d  = dir_y_q;
      flip_d   = flip_q;
      bounce_d = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            // speed is captured only here so mid-update changes are ignored
            if (bus.frame_tick && !bus.pause) begin
               step_d  = {1'b0, bus.speed} + 3'd1;
               flip_d  = 1'b0;
               state_d = MOVE_X;
            end
         end
         MOVE_X: begin
            ball_x_d = x_next;
            dir_x_d  = dir_x_q ^ x_flip;
            flip_d   = x_flip;
            state_d  = MOVE_Y;
         end
         MOVE_Y: begin
            ball_y_d = y_next;
            dir_y_d  = dir_y_q ^ y_flip;
            // registered strobes become visible during DONE
            done_d   = 1'b1;
            bounce_d = flip_q | y_flip;
            state_d  = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         step_q   <= 3'd1;
         ball_x_q <= X_RESET;
         ball_y_q <= Y_RESET;
         dir_x_q  <= 1'b1;
         dir_y_q  <= 1'b1;
         flip_q   <= 1'b0;
         bounce_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         ball_x_q <= ball_x_d;
         ball_y_q <= ball_y_d;
         dir_x_q  <= dir_x_d;
         dir_y_q  <= dir_y_d;
         flip_q   <= flip_d;
         bounce_q <= bounce_d;
         done_q   <= done_d;
      end
   end

   assign bus.ball_x      = ball_x_q;
   assign bus.ball_y      = ball_y_q;
   assign bus.dir_x       = dir_x_q;
   assign bus.dir_y       = dir_y_q;
   assign bus.bounce      = bounce_q;
   assign bus.update_done = done_q;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion with a reference model and an expectation
// queue that is drained on every update_done pulse.
module tb_ball_motion;

   localparam int X_LIM = 624;
   localparam int Y_LIM = 464;

   logic clk;
   logic rst_n;

   ball_motion_if #(.XW(10), .YW(10)) bus ();

   ball_motion #(
      .H_RES(640), .V_RES(480), .BALL_SIZE(16),
      .XW(10), .YW(10), .INIT_X(100), .INIT_Y(50)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      bit dx;
      bit dy;
      bit b;
   } exp_t;

   exp_t exp_q[$];

   int checks    = 0;
   int fails     = 0;
   int done_cnt  = 0;
   int bounce_cnt = 0;

   // reference model state
   int mx, my;
   bit mdx, mdy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mx = 100; my = 50; mdx = 1'b1; mdy = 1'b1;
   endtask

   task automatic model_axis(inout int p, inout bit d, input int st, input int lim, output bit fl);
      fl = 1'b0;
      if (d) begin
         if (p + st >= lim) begin p = lim; d = 1'b0; fl = 1'b1; end
         else p = p + st;
      end else begin
         if (p <= st) begin p = 0; d = 1'b1; fl = 1'b1; end
         else p = p - st;
      end
   endtask

   task automatic model_tick(input int spd);
      bit fx, fy;
      exp_t e;
      model_axis(mx, mdx, spd + 1, X_LIM, fx);
      model_axis(my, mdy, spd + 1, Y_LIM, fy);
      e.x = mx; e.y = my; e.dx = mdx; e.dy = mdy; e.b = fx | fy;
      exp_q.push_back(e);
   endtask

   // called at a negedge with the FSM idle; returns at a negedge with it idle again
   task automatic do_tick(input logic [1:0] spd);
      bus.speed      = spd;
      bus.pause      = 1'b0;
      bus.frame_tick = 1'b1;
      model_tick(int'(spd));
      @(negedge clk);
      bus.frame_tick = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_x"},    bus.ball_x, 100);
      chk({tag, "_y"},    bus.ball_y, 50);
      chk({tag, "_dx"},   bus.dir_x, 1);
      chk({tag, "_dy"},   bus.dir_y, 1);
      chk({tag, "_bnc"},  bus.bounce, 0);
      chk({tag, "_done"}, bus.update_done, 0);
   endtask

   // scoreboard side: every update_done must match the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (bus.bounce === 1'b1) begin
            bounce_cnt++;
            chk("bounce_with_done", bus.update_done, 1);
         end
         if (bus.update_done === 1'b1) begin
            done_cnt++;
            chk("pending_expect", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("upd_x",   bus.ball_x, e.x);
               chk("upd_y",   bus.ball_y, e.y);
               chk("upd_dx",  bus.dir_x, e.dx);
               chk("upd_dy",  bus.dir_y, e.dy);
               chk("upd_bnc", bus.bounce, e.b);
            end
         end
      end
   end

   initial begin
      int d0, b0, n, st, dxd, dyd, budget;

      rst_n = 1'b0;
      bus.frame_tick = 1'b0;
      bus.pause = 1'b0;
      bus.speed = 2'd0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset("rst1");
      rst_n = 1'b1;
      @(negedge clk);

      // single tick, step 1: latency x then y then done
      d0 = done_cnt;
      bus.speed = 2'd0;
      bus.frame_tick = 1'b1;
      model_tick(0);
      @(negedge clk);
      bus.frame_tick = 1'b0;
      chk("t2_x_k", bus.ball_x, 100);
      @(negedge clk);
      chk("t2_x_k1", bus.ball_x, 101);
      chk("t2_y_k1", bus.ball_y, 50);
      chk("t2_done_k1", bus.update_done, 0);
      @(negedge clk);
      chk("t2_y_k2", bus.ball_y, 51);
      chk("t2_done_k2", bus.update_done, 1);
      chk("t2_bnc_k2", bus.bounce, 0);
      @(negedge clk);
      chk("t2_done_k3", bus.update_done, 0);
      chk("t2_done_cnt", done_cnt - d0, 1);

      // right edge: walk to x=622 moving right, then overshoot to the limit
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      check_reset("rst2");
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 130; i++) do_tick(2'd3);
      do_tick(2'd1);
      chk("t3_x_pre", bus.ball_x, 622);
      chk("t3_dx_pre", bus.dir_x, 1);
      b0 = bounce_cnt;
      do_tick(2'd3);
      chk("t3_x_edge", bus.ball_x, 624);
      chk("t3_dx_edge", bus.dir_x, 0);
      chk("t3_bnc_cnt", bounce_cnt - b0, 1);
      do_tick(2'd3);
      chk("t3_x_back", bus.ball_x, 620);

      // pause: ticks dropped, speed changes ignored
      d0 = done_cnt;
      bus.pause = 1'b1;
      bus.speed = 2'd3;
      for (int i = 0; i < 5; i++) begin
         bus.frame_tick = 1'b1;
         @(negedge clk);
         bus.frame_tick = 1'b0;
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
      chk("t5_x_pause", bus.ball_x, mx);
      chk("t5_y_pause", bus.ball_y, my);
      chk("t5_dx_pause", bus.dir_x, mdx);
      chk("t5_dy_pause", bus.dir_y, mdy);
      chk("t5_done_pause", done_cnt - d0, 0);

      // tick held high for three cycles yields one update
      bus.pause = 1'b0;
      bus.speed = 2'd0;
      bus.frame_tick = 1'b1;
      model_tick(0);
      repeat (3) @(negedge clk);
      bus.frame_tick = 1'b0;
      repeat (4) @(negedge clk);
      chk("t5_done_held", done_cnt - d0, 1);
      chk("t5_x_held", bus.ball_x, mx);

      // reset asserted while in MOVE_Y
      bus.speed = 2'd0;
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset("t6_abort");
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_tick(2'd0);
      chk("t6_x_after", bus.ball_x, 101);
      chk("t6_y_after", bus.ball_y, 51);

      // corner: steer so both axes arrive at (2,2) moving left/up together.
      // X bounces land exactly; Y absorbs 14 pixels of overshoot, which
      // lines the two folded paths up at the 12th X / 16th Y wall.
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      budget = 14;
      n = 0;
      while (!(mx == 2 && my == 2 && !mdx && !mdy) && n < 3000) begin
         dxd = mdx ? (X_LIM - mx) : mx;
         dyd = mdy ? (Y_LIM - my) : my;
         if (!mdx && !mdy && mx == my && mx > 2) begin
            st = (mx - 2 > 4) ? 4 : mx - 2;
         end else if (dxd <= 4) begin
            st = dxd;
         end else if (dyd <= 4) begin
            if (budget == 0) st = dyd;
            else if (dyd == 4) st = 3;
            else begin
               st = (dyd + budget > 4) ? 4 : dyd + budget;
               budget = budget - (st - dyd);
            end
         end else begin
            st = 4;
         end
         do_tick(2'(st - 1));
         n++;
      end
      chk("t4_x_pre", bus.ball_x, 2);
      chk("t4_y_pre", bus.ball_y, 2);
      chk("t4_dx_pre", bus.dir_x, 0);
      chk("t4_dy_pre", bus.dir_y, 0);
      b0 = bounce_cnt;
      do_tick(2'd1);
      chk("t4_x", bus.ball_x, 0);
      chk("t4_y", bus.ball_y, 0);
      chk("t4_dx", bus.dir_x, 1);
      chk("t4_dy", bus.dir_y, 1);
      chk("t4_bnc_cnt", bounce_cnt - b0, 1);

      repeat (3) @(negedge clk);
      chk("queue_drain", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
